// File: rtl/axil_regfile_slave.sv
// AXI4-Lite slave in front of a NUM_REGS x DATA_WIDTH register bank with independent read/write FSMs.
// Optional define AXIL_REGFILE_PROT_CHECK_EN rejects unprivileged (PROT[0]=0) accesses with SLVERR.
module axil_regfile_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned NUM_REGS   = 16,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           WVALID,
  output logic                           WREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [STRB_WIDTH-1:0]          WSTRB,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [1:0]                     BRESP,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned OFFS = $clog2(STRB_WIDTH);
  localparam int unsigned IDXW = ADDR_WIDTH - OFFS;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                  aw_hs, w_hs, ar_hs;
  logic [IDXW-1:0]       aw_idx_q, wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wdata_q, wr_data, rd_data;
  logic [STRB_WIDTH-1:0] wstrb_q, wr_strb;
  logic                  wr_commit, wr_ok, wr_en, wr_priv, rd_ok, rd_priv;
  logic                  awready_nxt, wready_nxt, bvalid_nxt, arready_nxt, rvalid_nxt;
  logic [1:0]            bresp_nxt;
  logic [NUM_REGS-1:0]   wr_pulse_nxt;
  logic                  unused_inputs;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign rd_idx = ARADDR[ADDR_WIDTH-1:OFFS];
  assign unused_inputs = ^{AWADDR[OFFS-1:0], ARADDR[OFFS-1:0], AWPROT, ARPROT};

`ifdef AXIL_REGFILE_PROT_CHECK_EN
  logic awpriv_q;
  always_ff @(posedge ACLK) begin
    if (ARESET)     awpriv_q <= 1'b0;
    else if (aw_hs) awpriv_q <= AWPROT[0];
  end
  assign wr_priv = (w_state == W_HAVE_ADDR) ? awpriv_q : AWPROT[0];
  assign rd_priv = ARPROT[0];
`else
  assign wr_priv = 1'b1;
  assign rd_priv = 1'b1;
`endif

  // Write FSM next state; commit happens on whichever handshake completes the pair.
  always_comb begin
    w_next    = w_state;
    wr_commit = 1'b0;
    wr_idx    = (w_state == W_HAVE_ADDR) ? aw_idx_q : AWADDR[ADDR_WIDTH-1:OFFS];
    wr_data   = (w_state == W_HAVE_DATA) ? wdata_q : WDATA;
    wr_strb   = (w_state == W_HAVE_DATA) ? wstrb_q : WSTRB;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_next    = W_RESP;
          wr_commit = 1'b1;
        end else if (aw_hs) begin
          w_next = W_HAVE_ADDR;
        end else if (w_hs) begin
          w_next = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_hs) begin
        w_next    = W_RESP;
        wr_commit = 1'b1;
      end
      W_HAVE_DATA: if (aw_hs) begin
        w_next    = W_RESP;
        wr_commit = 1'b1;
      end
      W_RESP:  if (BVALID && BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
    wr_ok       = (32'(wr_idx) < NUM_REGS) && wr_priv;
    wr_en       = wr_commit && wr_ok;
    awready_nxt = (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
    wready_nxt  = (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
    bvalid_nxt  = (w_next == W_RESP);
    bresp_nxt   = wr_commit ? (wr_ok ? RESP_OKAY : RESP_SLVERR) : BRESP;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      wr_pulse_nxt[i] = wr_en && (wr_idx == IDXW'(i));
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state   <= W_IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      wr_pulse  <= '0;
      regs_flat <= '0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state  <= w_next;
      AWREADY  <= awready_nxt;
      WREADY   <= wready_nxt;
      BVALID   <= bvalid_nxt;
      BRESP    <= bresp_nxt;
      wr_pulse <= wr_pulse_nxt;
      if (aw_hs) aw_idx_q <= AWADDR[ADDR_WIDTH-1:OFFS];
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        for (int b = 0; b < int'(STRB_WIDTH); b++) begin
          if (wr_en && (wr_idx == IDXW'(i)) && wr_strb[b])
            regs_flat[i*DATA_WIDTH + b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read FSM next state and lookup; a same-edge write is not yet visible here.
  always_comb begin
    r_next  = r_state;
    rd_data = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_idx == IDXW'(i)) rd_data = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end
    rd_ok = (32'(rd_idx) < NUM_REGS) && rd_priv;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (RVALID && RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
    arready_nxt = (r_next == R_IDLE);
    rvalid_nxt  = (r_next == R_DATA);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      ARREADY <= arready_nxt;
      RVALID  <= rvalid_nxt;
      if (ar_hs) begin
        RDATA <= rd_ok ? rd_data : '0;
        RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Self-checking bench for axil_regfile_slave: directed test-plan steps followed by
// randomized reads/writes scored against an array model of the register bank.
module tb_axil_regfile_slave;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;
  localparam int unsigned NR = 16;
  localparam int unsigned SW = DW / 8;

  logic             ACLK, ARESET;
  logic             AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic             ARVALID, ARREADY, RVALID, RREADY;
  logic [AW-1:0]    AWADDR, ARADDR;
  logic [2:0]       AWPROT, ARPROT;
  logic [DW-1:0]    WDATA, RDATA;
  logic [SW-1:0]    WSTRB;
  logic [1:0]       BRESP, RRESP;
  logic [NR*DW-1:0] regs_flat;
  logic [NR-1:0]    wr_pulse;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [NR];

  axil_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .regs_flat(regs_flat), .wr_pulse(wr_pulse)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < int'(NR); i++) chk(tag, 64'(regs_flat[i*DW +: DW]), 64'(model[i]));
  endtask

  // Model: word index is addr/4; beyond the bank (or unprivileged when checked) is an error.
  function automatic logic access_ok(input logic [AW-1:0] addr, input logic [2:0] prot);
    logic ok;
    ok = int'(addr[AW-1:2]) < int'(NR);
`ifdef AXIL_REGFILE_PROT_CHECK_EN
    ok = ok && prot[0];
`endif
    return ok;
  endfunction

  function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                      input logic [SW-1:0] strb, input logic [2:0] prot);
    int idx;
    idx = int'(addr[AW-1:2]);
    if (!access_ok(addr, prot)) return;
    for (int b = 0; b < int'(SW); b++)
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
  endfunction

  // w_lead > 0: W goes first and AW follows w_lead cycles later; < 0: AW first; 0: together.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [SW-1:0] strb, input logic [2:0] prot,
                           input int w_lead, input int b_hold);
    logic ok;
    logic [NR-1:0] exp_pulse;
    ok = access_ok(addr, prot);
    exp_pulse = ok ? (NR'(1) << int'(addr[AW-1:2])) : '0;
    AWADDR = addr; AWPROT = prot; WDATA = data; WSTRB = strb;
    if (w_lead >= 0) begin
      WVALID = 1'b1;
      AWVALID = (w_lead == 0);
      tick();
      WVALID = 1'b0; AWVALID = 1'b0;
      if (w_lead > 0) begin
        for (int k = 1; k < w_lead; k++) begin
          chk("wready_low_wait_aw", 64'(WREADY), 64'(0));
          chk("awready_high_wait_aw", 64'(AWREADY), 64'(1));
          tick();
        end
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
      end
    end else begin
      AWVALID = 1'b1;
      tick();
      AWVALID = 1'b0;
      for (int k = 1; k < -w_lead; k++) begin
        chk("awready_low_wait_w", 64'(AWREADY), 64'(0));
        chk("wready_high_wait_w", 64'(WREADY), 64'(1));
        tick();
      end
      WVALID = 1'b1;
      tick();
      WVALID = 1'b0;
    end
    model_write(addr, data, strb, prot);
    chk("bvalid_latency", 64'(BVALID), 64'(1));
    chk("bresp", 64'(BRESP), ok ? 64'(0) : 64'(2));
    chk("wr_pulse_first", 64'(wr_pulse), 64'(exp_pulse));
    for (int k = 0; k < b_hold; k++) begin
      tick();
      chk("bvalid_hold", 64'(BVALID), 64'(1));
      chk("bresp_hold", 64'(BRESP), ok ? 64'(0) : 64'(2));
      chk("readys_low_in_resp", 64'({AWREADY, WREADY}), 64'(0));
      chk("wr_pulse_once", 64'(wr_pulse), 64'(0));
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("bvalid_drop", 64'(BVALID), 64'(0));
    chk("wr_pulse_drop", 64'(wr_pulse), 64'(0));
    chk("readys_back", 64'({AWREADY, WREADY}), 64'(3));
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input logic [2:0] prot);
    logic ok;
    ok = access_ok(addr, prot);
    ARADDR = addr; ARPROT = prot; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0; RREADY = 1'b1;
    chk("rvalid_latency", 64'(RVALID), 64'(1));
    chk("rdata", 64'(RDATA), ok ? 64'(model[int'(addr[AW-1:2])]) : 64'(0));
    chk("rresp", 64'(RRESP), ok ? 64'(0) : 64'(2));
    chk("arready_low_in_data", 64'(ARREADY), 64'(0));
    tick();
    RREADY = 1'b0;
    chk("rvalid_drop", 64'(RVALID), 64'(0));
    chk("arready_back", 64'(ARREADY), 64'(1));
  endtask

  initial begin
    logic [AW-1:0] a;
    ARESET = 1'b1;
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
    AWADDR = '0; ARADDR = '0; AWPROT = 3'b001; ARPROT = 3'b001; WDATA = '0; WSTRB = '0;
    for (int i = 0; i < int'(NR); i++) model[i] = '0;

    // Reset state and READY rise one cycle after release.
    tick(); tick();
    ARESET = 1'b0;
    chk("reset_readys_low", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
    chk("reset_valids_low", 64'({BVALID, RVALID}), 64'(0));
    chk("reset_resp_data", 64'({BRESP, RRESP, RDATA}), 64'(0));
    chk("reset_wr_pulse", 64'(wr_pulse), 64'(0));
    chk_regs("reset_regs");
    tick();
    chk("readys_after_release", 64'({AWREADY, WREADY, ARREADY}), 64'(7));

    // AW+W together to reg2, then W first with sparse strobes, then long B stall.
    axi_write(12'h008, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0);
    chk("reg2_first", 64'(regs_flat[2*DW +: DW]), 64'h0000_0000_DEAD_BEEF);
    axi_write(12'h008, 32'h11223344, 4'b0101, 3'b001, 3, 0);
    chk("reg2_strobed", 64'(regs_flat[2*DW +: DW]), 64'h0000_0000_DE22_BE44);
    axi_write(12'h00C, 32'hCAFEF00D, 4'hF, 3'b001, 0, 5);
    axi_write(12'h014, 32'h0BADC0DE, 4'hF, 3'b001, -2, 1);
    chk_regs("regs_after_directed_writes");

    // Boundaries: empty strobe, offset bits ignored, out-of-range write.
    axi_write(12'h004, 32'hFFFFFFFF, 4'h0, 3'b001, 0, 0);
    axi_write(12'h03F, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 0);
    axi_write(12'hFFC, 32'h12345678, 4'hF, 3'b001, 0, 0);
    axi_write(12'h040, 32'h87654321, 4'hF, 3'b001, 1, 0);
    chk_regs("regs_after_boundary_writes");

    // Out-of-range read back-to-back with an in-range read.
    axi_read(12'h040, 3'b001);
    axi_read(12'h008, 3'b001);

    // Same-edge read and write to reg0 returns the pre-write value.
    axi_write(12'h000, 32'h5, 4'hF, 3'b001, 0, 0);
    AWADDR = 12'h000; ARADDR = 12'h000; WDATA = 32'hA; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("same_edge_rdata_old", 64'(RDATA), 64'h5);
    chk("same_edge_bvalid", 64'(BVALID), 64'(1));
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    model[0] = 32'hA;
    axi_read(12'h000, 3'b001);

    // Randomized traffic; index range 0..19 exercises out-of-range decode.
    for (int n = 0; n < 60; n++) begin
      a = AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, SW'($urandom), 3'($urandom),
                  int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
      else
        axi_read(a, 3'($urandom));
    end
    chk_regs("regs_after_random");

    // Reset mid-transaction with both response channels pending.
    AWADDR = 12'h004; WDATA = 32'h77; WSTRB = 4'hF; ARADDR = 12'h004;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("pre_reset_valids", 64'({BVALID, RVALID}), 64'(3));
    ARESET = 1'b1;
    tick();
    for (int i = 0; i < int'(NR); i++) model[i] = '0;
    chk("reset_mid_valids", 64'({BVALID, RVALID}), 64'(0));
    chk_regs("reset_mid_regs");
    ARESET = 1'b0;
    chk("reset_mid_readys_low", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
    tick();
    chk("reset_mid_readys_back", 64'({AWREADY, WREADY, ARREADY}), 64'(7));
    axi_write(12'h01C, 32'h600DF00D, 4'hF, 3'b001, 0, 0);
    axi_read(12'h01C, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
